uart_rx: RTL and testbench

- UART receiver: the receive-side counterpart to the UART transmitter.
- Deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line.
- Uses the same 20-bit baud divisor convention as the transmitter: clock cycles per bit.
- Presents the received byte with a valid flag, a host clear strobe, and sticky framing and overrun error flags for the SoC register interface.

---
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling, byte + valid
// with host clear strobe and sticky framing / overrun flags.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    input  logic [19:0] baud,
    input  logic        rd,
    output logic [7:0]  dout,
    output logic        rx_valid,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [19:0]            baud_r;
    logic [19:0]            cnt;
    logic [2:0]             idx;
    logic [7:0]             shift;
    logic [19:0]            half_m1;
    logic [19:0]            full_m1;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_busy = (state != IDLE);
    assign half_m1 = {1'b0, baud_r[19:1]} - 20'd1;
    assign full_m1 = baud_r - 20'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            baud_r    <= 20'd0;
            cnt       <= 20'd0;
            idx       <= 3'd0;
            shift     <= 8'd0;
            dout      <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Host clear first so a same-cycle set below takes priority
            if (rd) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= 20'd0;
                        baud_r <= baud;
                    end
                end
                START: begin
                    if (cnt == half_m1) begin
                        cnt <= 20'd0;
                        idx <= 3'd0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                DATA: begin
                    if (cnt == full_m1) begin
                        shift[idx] <= rx_s;
                        cnt        <= 20'd0;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                STOP: begin
                    if (cnt == full_m1) begin
                        cnt <= 20'd0;
                        if (rx_s) begin
                            dout     <= shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rd) begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                BRK: begin
                    // Hold off until the line recovers so a break is one error
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, corner sequences and
// randomized frames checked against a frame-level flag model.
module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic        rx_in;
    logic [19:0] baud;
    logic        rd;
    logic [7:0]  dout;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int start_cyc;
    int rise_cyc;
    int busy_cnt;
    logic prev_valid = 1'b0;
    logic busy_at_release;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .baud     (baud),
        .rd       (rd),
        .dout     (dout),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_busy) busy_cnt = busy_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        bit         rd_before;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    // Drive one frame; stop_low>0 holds the stop bit low for that many bits
    task automatic send_frame(input logic [7:0] d, input int stop_low,
                              input int b, input bit scramble);
        baud = 20'(b);
        start_cyc = cyc;
        rx_in = 1'b0;
        if (scramble) begin
            repeat (b / 2) @(negedge clk);
            baud = 20'($urandom_range(4, 1000));
            repeat (b - b / 2) @(negedge clk);
        end else begin
            repeat (b) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (b) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx_in = 1'b0;
            repeat (stop_low * b) @(negedge clk);
            busy_at_release = rx_busy;
        end
        rx_in = 1'b1;
        repeat (2 * b) @(negedge clk);
        baud = 20'(b);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_d,
                           input logic e_v, input logic e_f,
                           input logic e_o);
        chk({tag, "_dout"}, 32'(dout), 32'(e_d));
        chk({tag, "_valid"}, 32'(rx_valid), 32'(e_v));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(e_f));
        chk({tag, "_ovr"}, 32'(overrun), 32'(e_o));
    endtask

    initial begin
        logic [7:0] m_dout;
        logic       m_valid, m_ferr, m_ovr;
        logic [7:0] d;
        int         b, sl, lat;
        bit         do_rd, scr;

        vecs[0] = '{8'h55, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        rx_in = 1'b1;
        baud = 20'd16;
        rd = 1'b0;
        busy_cnt = 0;
        rise_cyc = -1;
        repeat (3) @(negedge clk);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", 32'(rx_busy), 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rd_before) begin
                pulse_rd();
                chk("rd_clears_valid", 32'(rx_valid), 32'd0);
            end
            rise_cyc = -1;
            send_frame(vecs[i].data, 0, 16, 1'b0);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_dout,
                    vecs[i].exp_valid, vecs[i].exp_ferr, vecs[i].exp_ovr);
            chk($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'd0);
            if (i == 0) begin
                lat = rise_cyc - start_cyc;
                n_chk++;
                if (rise_cyc < 0 || lat < 153 || lat > 155) begin
                    n_fail++;
                    $display("FAIL latency: got %0d expected 153..155", lat);
                end
            end
        end

        pulse_rd();
        chk_out("rd_all", 8'h22, 1'b0, 1'b0, 1'b0);

        busy_at_release = 1'b0;
        send_frame(8'h7E, 3, 16, 1'b0);
        chk("brk_held", 32'(busy_at_release), 32'd1);
        chk_out("brk", 8'h22, 1'b0, 1'b1, 1'b0);
        chk("brk_busy", 32'(rx_busy), 32'd0);

        busy_cnt = 0;
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        rx_in = 1'b1;
        repeat (32) @(negedge clk);
        n_chk++;
        if (busy_cnt < 1 || busy_cnt > 10) begin
            n_fail++;
            $display("FAIL glitch_busy: got %0d expected 1..10", busy_cnt);
        end
        chk_out("glitch", 8'h22, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC5, 0, 16, 1'b0);
        chk_out("after_glitch", 8'hC5, 1'b1, 1'b1, 1'b0);

        baud = 20'd10;
        d = 8'hA5;
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            repeat (10) @(negedge clk);
        end
        rx_in = d[4];
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rx_in = 1'b1;
        chk_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst_busy", 32'(rx_busy), 32'd0);
        repeat (20) @(negedge clk);
        chk_out("midrst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 0, 10, 1'b0);
        chk_out("post_rst", 8'h3C, 1'b1, 1'b0, 1'b0);

        m_dout = 8'h3C;
        m_valid = 1'b1;
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom_range(0, 255));
            b = $urandom_range(8, 24);
            sl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            do_rd = $urandom_range(0, 1) == 1;
            scr = $urandom_range(0, 1) == 1;
            if (do_rd) begin
                pulse_rd();
                m_valid = 1'b0;
                m_ferr = 1'b0;
                m_ovr = 1'b0;
            end
            send_frame(d, sl, b, scr);
            if (sl == 0) begin
                m_ovr = m_ovr | m_valid;
                m_valid = 1'b1;
                m_dout = d;
            end else begin
                m_ferr = 1'b1;
            end
            chk_out($sformatf("rnd%0d", n), m_dout, m_valid, m_ferr, m_ovr);
            chk($sformatf("rnd%0d_busy", n), 32'(rx_busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
